if_fetch_stage: RTL
===================

// Module: if_fetch_stage
// PURPOSE
//  Instruction-fetch stage directly upstream of the byte-addressed instruction memory.
//  - Owns the program counter and drives the memory's 32-bit readAddress.
//  - Takes the memory's combinational, big-endian 32-bit word and registers it into the IF/ID pipeline register.
//  - Handles stall, flush, branch/jump redirect and a halt/resume state machine.
// PARAMETERS
//  RESET_PC   32'h0000_0000  PC value loaded on reset; must be word aligned
//  MEM_BYTES  256            instruction memory size in bytes (power of 2, >= 8); PC wraps modulo this
// PORTS
//  clk           in   1   rising-edge clock, sole clock
//  rst_n         in   1   asynchronous, active-low reset
//  stall         in   1   hazard stall from ID: hold PC and IF/ID
//  flush         in   1   squash IF/ID contents (bubble); PC still advances
//  redirectEn    in   1   taken branch/jump this cycle
//  redirectAddr  in   32  branch/jump target byte address
//  haltReq       in   1   request to stop fetching
//  resumeReq     in   1   leave HALTED
//  instrIn       in   32  word returned by instruction memory for readAddress
//  readAddress   out  32  byte address to instruction memory (= PC)
//  ifidInstr     out  32  registered instruction (32'h0000_0000 when bubble)
//  ifidPc        out  32  PC of ifidInstr
//  ifidPcPlus4   out  32  (ifidPc + 4) mod MEM_BYTES
//  ifidValid     out  1   IF/ID holds a real instruction
//  halted        out  1   FSM in HALTED
//  misaligned    out  1   sticky: a redirect target had addr[1:0] != 0
//  fetchCount    out  16  valid instructions delivered, saturates at 16'hFFFF
// BEHAVIOUR
//  Reset (async, rst_n=0):
//   - PC=RESET_PC; ifidInstr=0, ifidPc=0, ifidPcPlus4=0, ifidValid=0.
//   - halted=0, misaligned=0, fetchCount=0; FSM=BOOT.
//   - Reset mid-stall/halt discards all state.
//  readAddress = PC, combinational from the PC register. Memory is combinational, so instrIn is valid in the same cycle.
//  FSM: BOOT -> RUN (unconditionally, 1 cycle; IF/ID loads the first fetched word at the end of BOOT).
//   - RUN -> HALTED when haltReq=1 and redirectEn=0.
//   - HALTED -> RUN when resumeReq=1. haltReq and resumeReq together in HALTED: stay HALTED.
//  Per-edge priority in BOOT/RUN: redirectEn > flush > stall > normal.
//   - redirectEn: PC <= {redirectAddr[31:2],2'b00} mod MEM_BYTES; IF/ID <= bubble (wrong-path word dropped).
//     If redirectAddr[1:0]!=0, misaligned <= 1 (sticky until reset). Overrides stall.
//   - flush (no redirect): IF/ID <= bubble; PC <= PC+4 unless stall=1 (then PC holds).
//   - stall (alone): PC and all IF/ID outputs hold; fetchCount holds.
//   - normal: IF/ID <= {instrIn, PC, PC+4, valid=1}; PC <= PC+4; fetchCount++ (saturating).
//  HALTED:
//   - PC holds; IF/ID <= bubble each cycle; halted=1.
//   - redirectEn in HALTED updates PC (and misaligned) but the FSM stays HALTED.
//   - On resume, the first fetch is from the held PC.
//  Arithmetic:
//   - PC+4 computed modulo MEM_BYTES: upper bits of PC are always 0.
//   - PC = MEM_BYTES-4 wraps to 0; ifidPcPlus4 uses the same wrap.
//  Bubble = ifidInstr 0, ifidValid 0, ifidPc/ifidPcPlus4 hold previous values.
//  Latency: instruction at address A appears on ifidInstr one edge after PC==A with no stall.
// TESTING
//  1 Reset, RESET_PC=0, mem words W0..W3 at 0,4,8,12, no stall -> ifidInstr W0,W1,W2 on edges 1-3; ifidPc 0,4,8; fetchCount=3.
//  2 stall=1 for 2 cycles while PC=8 -> readAddress stays 8, IF/ID frozen; on release next ifidPc=8, no duplicate count.
//  3 redirectEn=1 with redirectAddr=0x40 plus stall=1 -> next: readAddress 0x40, ifidValid=0; following edge ifidPc=0x40.
//  4 redirectAddr=0x43 -> PC=0x40, misaligned=1 and stays 1 through further redirects until rst_n=0.
//  5 PC=252 (MEM_BYTES=256), normal run -> ifidPcPlus4=0, readAddress=0 next cycle, ifidPc sequence 252,0.
//  6 haltReq at PC=0x10 -> halted=1, ifidValid=0, PC held; rst_n pulse while halted -> PC=RESET_PC, FSM=BOOT, halted=0.

Source files
------------

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives the instruction memory address and
// registers the returned big-endian word into the IF/ID register with stall/flush/redirect/halt control.
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          MEM_BYTES = 256
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        flush,
    input  logic        redirectEn,
    input  logic [31:0] redirectAddr,
    input  logic        haltReq,
    input  logic        resumeReq,
    input  logic [31:0] instrIn,
    output logic [31:0] readAddress,
    output logic [31:0] ifidInstr,
    output logic [31:0] ifidPc,
    output logic [31:0] ifidPcPlus4,
    output logic        ifidValid,
    output logic        halted,
    output logic        misaligned,
    output logic [15:0] fetchCount
);

    localparam logic [31:0] ADDR_MASK = 32'(MEM_BYTES - 1);

    typedef enum logic [1:0] {
        BOOT   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } state_t;

    state_t      state;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] redirect_pc;

    // Masking keeps every PC bit above the memory size at zero, which also gives the wrap.
    assign pc_plus4    = (pc + 32'd4) & ADDR_MASK;
    assign redirect_pc = {redirectAddr[31:2], 2'b00} & ADDR_MASK;
    assign readAddress = pc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= BOOT;
            pc          <= RESET_PC & ADDR_MASK;
            ifidInstr   <= 32'h0000_0000;
            ifidPc      <= 32'h0000_0000;
            ifidPcPlus4 <= 32'h0000_0000;
            ifidValid   <= 1'b0;
            halted      <= 1'b0;
            misaligned  <= 1'b0;
            fetchCount  <= 16'h0000;
        end else begin
            if (redirectEn) begin
                pc <= redirect_pc;
                if (redirectAddr[1:0] != 2'b00) begin
                    misaligned <= 1'b1;
                end
            end

            case (state)
                HALTED: begin
                    ifidInstr <= 32'h0000_0000;
                    ifidValid <= 1'b0;
                    if (resumeReq && !haltReq) begin
                        state  <= RUN;
                        halted <= 1'b0;
                    end
                end
                default: begin
                    state <= RUN;
                    if (redirectEn) begin
                        ifidInstr <= 32'h0000_0000;
                        ifidValid <= 1'b0;
                    end else if (state == RUN && haltReq) begin
                        // Halting stops the fetch on this very edge: PC holds, IF/ID drains.
                        state     <= HALTED;
                        halted    <= 1'b1;
                        ifidInstr <= 32'h0000_0000;
                        ifidValid <= 1'b0;
                    end else if (flush) begin
                        ifidInstr <= 32'h0000_0000;
                        ifidValid <= 1'b0;
                        if (!stall) begin
                            pc <= pc_plus4;
                        end
                    end else if (!stall) begin
                        ifidInstr   <= instrIn;
                        ifidPc      <= pc;
                        ifidPcPlus4 <= pc_plus4;
                        ifidValid   <= 1'b1;
                        pc          <= pc_plus4;
                        if (fetchCount != 16'hFFFF) begin
                            fetchCount <= fetchCount + 16'd1;
                        end
                    end
                end
            endcase
        end
    end

endmodule
